branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Branch-resolution controller sitting between the Execute stage and the branch predictor's update port. It checks each resolved branch against the prediction carried down the pipeline and, on a mispredict, runs a flush/redirect sequence for Fetch. Every resolved branch is queued in a small FIFO that drains one entry per cycle into the predictor's BTB/PHT update port, so a busy predictor never drops training data.

## Interface
- `DEPTH`, 4: update-queue entries (power of two, ≥2).
- `FLUSH_CYCLES`, 2: cycles `flush` stays high per mispredict (≥1).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  Execute holds a valid instruction.
- `ex_is_branch`  in  1  that instruction is a conditional branch or jump.
- `ex_pc`  in  32  PC of the branch.
- `ex_target`  in  32  computed target (ALU output).
- `ex_taken`  in  1  actual outcome.
- `ex_pred_valid`  in  1  Fetch predicted taken (pipelined `prediction_valid`).
- `ex_pred_pc`  in  32  PC Fetch went to after this branch.
- `ex_ghr`  in  4  GHR snapshot carried with the branch.
- `upd_hold`  in  1  predictor cannot accept an update this cycle.
- `flush`  out  1  kill IF/ID/EX younger instructions.
- `redirect_valid`  out  1  one-cycle pulse: load `redirect_pc` into the PC.
- `redirect_pc`  out  32  corrected fetch address.
- `ex_stall`  out  1  queue full; Execute must hold its branch.
- `branch_resolved`  out  1  update strobe to predictor.
- `resolved_pc`, `alu_out`  out  32  head entry's PC and target.
- `branch_taken`  out  1  head entry's outcome.
- `ghr_history`  out  4  head entry's GHR.
- `perf_branches`, `perf_mispredicts`  out  32  performance counters (see Configuration).

## Operation
- Accept: `acc = ex_valid & ex_is_branch & (state==IDLE)`. In FLUSH, Execute contents are wrong-path and are ignored entirely: no enqueue, no mispredict check.
- Actual next PC: `nxt = ex_taken ? ex_target : ex_pc + 32'd4`. The add is modulo 2^32, so `0xFFFFFFFC+4 = 0`.
- Mispredict: `acc & (ex_pred_pc != nxt)`. This covers a wrong direction and a wrong target in one compare.
- FSM states:
  - IDLE: on mispredict, go to FLUSH; register `redirect_pc <= nxt`; pulse `redirect_valid`; load the flush counter with `FLUSH_CYCLES-1`.
  - FLUSH: `flush = 1`. Decrement the counter. At 0, return to IDLE.
- Queue: `DEPTH`-entry circular FIFO of {pc, target, taken, ghr}.
  - Enqueue on `acc & ~ex_stall`. Mispredicted branches are enqueued too.
  - Pointers wrap modulo `DEPTH`. Occupancy count has width log2(DEPTH)+1.
- Drain: `branch_resolved = ~empty & ~upd_hold`. Update outputs show the head entry combinationally. A dequeue happens when `branch_resolved` is high. When empty, the update outputs are 0.
- `ex_stall = full & ~branch_resolved`. When full and draining in the same cycle, the enqueue is accepted and occupancy stays at `DEPTH`.
- Empty queue with an enqueue: the entry is visible on the port the next cycle, not the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, queue empty, counters 0. Asserting reset mid-flush or with a non-empty queue discards everything immediately.
- Mispredicting branch in EX during cycle N:
  - `redirect_valid` is high in cycle N+1 only, with `redirect_pc` valid in N+1.
  - `flush` is high in cycles N+1 .. N+FLUSH_CYCLES.
  - The next branch is accepted no earlier than cycle N+FLUSH_CYCLES+1.
- `redirect_pc` holds its last value after the pulse.
- Update latency: a branch accepted in cycle N drives `branch_resolved` in N+1 at the earliest. Each cycle of `upd_hold` adds one cycle.
- Throughput: one update per cycle.
- `flush`, `redirect_valid` and `redirect_pc` are registered. `ex_stall` and `branch_resolved` are combinational from registered state and `upd_hold`.

## Configuration
- `BRC_PERF_CNT_EN` defined:
  - `perf_branches` increments on every accepted branch.
  - `perf_mispredicts` increments on every mispredict.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by `rst`.
- `BRC_PERF_CNT_EN` undefined: no counter flops; both outputs are tied to 0.

## Test plan
- Correct predictions: taken branch at pc 0x100, target 0x200, pred 0x200, then not-taken at 0x204, pred 0x208.
  - Required: no `flush` or `redirect_valid`.
  - Required: `branch_resolved` in the following two cycles with (0x100, 0x200, 1) then (0x204, *, 0).
- Direction mispredict: pc 0x40, taken, target 0x80, pred 0x44, FLUSH_CYCLES=2.
  - Required: `redirect_valid`=1 with `redirect_pc`=0x80 for 1 cycle.
  - Required: `flush`=1 for 2 cycles; a branch presented during those cycles is neither queued nor checked.
- Fill and hold: hold `upd_hold`=1 and send 5 branches with DEPTH=4.
  - Required: `ex_stall` rises after the 4th branch; the 5th is accepted only once drained.
  - Releasing `upd_hold` drains the entries in FIFO order, one per cycle, across pointer wrap.
- Full with simultaneous drain: queue full, `upd_hold`=0, new branch presented.
  - Required: `ex_stall`=0, occupancy stays 4, the new entry sits at the tail.
- Wrap and reset: not-taken branch at pc 0xFFFFFFFC with pred 0x0, so no mispredict. Then assert `rst` mid-flush after a separate mispredict.
  - Required: all outputs 0 immediately; queue empty after release.
- With `BRC_PERF_CNT_EN`: 3 branches, 1 mispredicted.
  - Required: counts 3 and 1. Without the macro, both read 0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Checks each branch resolved in Execute against the prediction carried
//   down the pipeline. On a mispredict it raises a one-cycle redirect and
//   holds flush for FLUSH_CYCLES cycles. Every accepted branch is also queued
//   in a DEPTH-entry FIFO that drains one entry per cycle into the
//   predictor's update port.
//
// Optional feature: define BRC_PERF_CNT_EN to build the saturating
//   perf_branches_o / perf_mispredicts_o counters; otherwise both are tied 0.
//
// Ports
//   clk_i, rst_i             clock (rising edge), async active-high reset
//   ex_*_i                   branch in Execute: valid, is_branch, pc, target,
//                            taken, pred_valid, pred_pc, ghr snapshot
//   upd_hold_i               predictor cannot take an update this cycle
//   flush_o                  kill younger IF/ID/EX instructions
//   redirect_valid_o/pc_o    one-cycle redirect pulse, corrected fetch PC
//   ex_stall_o               queue full, Execute must hold its branch
//   branch_resolved_o        update strobe (head entry valid and accepted)
//   resolved_pc_o, alu_out_o, branch_taken_o, ghr_history_o
//                            head entry fields, 0 when the queue is empty
//   perf_branches_o, perf_mispredicts_o
//                            performance counters
module branch_resolve_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_taken_i,
  input  logic        ex_pred_valid_i,
  input  logic [31:0] ex_pred_pc_i,
  input  logic [3:0]  ex_ghr_i,
  input  logic        upd_hold_i,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        ex_stall_o,
  output logic        branch_resolved_o,
  output logic [31:0] resolved_pc_o,
  output logic [31:0] alu_out_o,
  output logic        branch_taken_o,
  output logic [3:0]  ghr_history_o,
  output logic [31:0] perf_branches_o,
  output logic [31:0] perf_mispredicts_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned FcW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [FcW-1:0]  FcInit  = FcW'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q;
  logic              flush_q;
  logic              redirect_valid_q;
  logic [31:0]       redirect_pc_q;
  logic [FcW-1:0]    fcnt_q;

  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       tgt_mem_q   [DEPTH];
  logic              taken_mem_q [DEPTH];
  logic [3:0]        ghr_mem_q   [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              acc;
  logic [31:0]       nxt_pc;
  logic              mispredict;
  logic              empty;
  logic              full;
  logic              enq;
  logic              deq;

  // The direction bit is implied by the pred_pc compare, so it is not used.
  logic              unused_pred_valid;
  assign unused_pred_valid = ex_pred_valid_i;

  // Wrong-path instructions during a flush are neither queued nor checked.
  assign acc        = ex_valid_i & ex_is_branch_i & (state_q == StIdle);
  assign nxt_pc     = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
  assign mispredict = acc & (ex_pred_pc_i != nxt_pc);

  assign empty             = (count_q == '0);
  assign full              = (count_q == FullCnt);
  assign branch_resolved_o = ~empty & ~upd_hold_i;
  // A full queue that drains this cycle still has room for the new entry.
  assign ex_stall_o        = full & ~branch_resolved_o;
  assign enq               = acc & ~ex_stall_o;
  assign deq               = branch_resolved_o;

  // Flush / redirect sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      fcnt_q           <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          redirect_valid_q <= mispredict;
          if (mispredict) begin
            state_q       <= StFlush;
            flush_q       <= 1'b1;
            redirect_pc_q <= nxt_pc;
            fcnt_q        <= FcInit;
          end
        end
        StFlush: begin
          redirect_valid_q <= 1'b0;
          if (fcnt_q == '0) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - FcW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

  // Queue pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only visible while count_q != 0.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= ex_pc_i;
      tgt_mem_q[wr_ptr_q]   <= ex_target_i;
      taken_mem_q[wr_ptr_q] <= ex_taken_i;
      ghr_mem_q[wr_ptr_q]   <= ex_ghr_i;
    end
  end

  assign resolved_pc_o  = empty ? 32'd0 : pc_mem_q[rd_ptr_q];
  assign alu_out_o      = empty ? 32'd0 : tgt_mem_q[rd_ptr_q];
  assign branch_taken_o = empty ? 1'b0  : taken_mem_q[rd_ptr_q];
  assign ghr_history_o  = empty ? 4'd0  : ghr_mem_q[rd_ptr_q];

`ifdef BRC_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  // Saturating counters: stop at all-ones rather than wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      if (acc && (perf_br_q != '1)) begin
        perf_br_q <= perf_br_q + 32'd1;
      end
      if (mispredict && (perf_mis_q != '1)) begin
        perf_mis_q <= perf_mis_q + 32'd1;
      end
    end
  end

  assign perf_branches_o    = perf_br_q;
  assign perf_mispredicts_o = perf_mis_q;
`else
  assign perf_branches_o    = 32'd0;
  assign perf_mispredicts_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: a directed vector table, hand-written
// fill/wrap/reset sequences, and a randomized phase against a queue-based
// reference model.
module tb_branch_resolve_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FC    = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, ex_is_branch_i, ex_taken_i, ex_pred_valid_i, upd_hold_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_pred_pc_i;
  logic [3:0]  ex_ghr_i;
  logic        flush_o, redirect_valid_o, ex_stall_o, branch_resolved_o, branch_taken_o;
  logic [31:0] redirect_pc_o, resolved_pc_o, alu_out_o, perf_branches_o, perf_mispredicts_o;
  logic [3:0]  ghr_history_o;

  always #5 clk_i = ~clk_i;

  branch_resolve_ctrl #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .ex_valid_i         (ex_valid_i),
    .ex_is_branch_i     (ex_is_branch_i),
    .ex_pc_i            (ex_pc_i),
    .ex_target_i        (ex_target_i),
    .ex_taken_i         (ex_taken_i),
    .ex_pred_valid_i    (ex_pred_valid_i),
    .ex_pred_pc_i       (ex_pred_pc_i),
    .ex_ghr_i           (ex_ghr_i),
    .upd_hold_i         (upd_hold_i),
    .flush_o            (flush_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .ex_stall_o         (ex_stall_o),
    .branch_resolved_o  (branch_resolved_o),
    .resolved_pc_o      (resolved_pc_o),
    .alu_out_o          (alu_out_o),
    .branch_taken_o     (branch_taken_o),
    .ghr_history_o      (ghr_history_o),
    .perf_branches_o    (perf_branches_o),
    .perf_mispredicts_o (perf_mispredicts_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic [3:0]  ghr;
  } ent_t;

  ent_t        mq[$];
  int          flush_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_pb, m_pm;

  function automatic void model_reset();
    mq.delete();
    flush_left = 0;
    m_rv       = 1'b0;
    m_rpc      = '0;
    m_pb       = '0;
    m_pm       = '0;
  endfunction

  function automatic void model_cmp();
    logic br;
    br = (mq.size() > 0) && !upd_hold_i;
    chk("flush", {31'd0, flush_o}, {31'd0, flush_left > 0});
    chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, m_rv});
    chk("redirect_pc", redirect_pc_o, m_rpc);
    chk("branch_resolved", {31'd0, branch_resolved_o}, {31'd0, br});
    chk("ex_stall", {31'd0, ex_stall_o}, {31'd0, (mq.size() == DEPTH) && !br});
    if (mq.size() > 0) begin
      chk("resolved_pc", resolved_pc_o, mq[0].pc);
      chk("alu_out", alu_out_o, mq[0].tgt);
      chk("branch_taken", {31'd0, branch_taken_o}, {31'd0, mq[0].tk});
      chk("ghr_history", {28'd0, ghr_history_o}, {28'd0, mq[0].ghr});
    end else begin
      chk("resolved_pc_empty", resolved_pc_o, 32'd0);
      chk("alu_out_empty", alu_out_o, 32'd0);
      chk("taken_empty", {31'd0, branch_taken_o}, 32'd0);
      chk("ghr_empty", {28'd0, ghr_history_o}, 32'd0);
    end
`ifdef BRC_PERF_CNT_EN
    chk("perf_branches", perf_branches_o, m_pb);
    chk("perf_mispredicts", perf_mispredicts_o, m_pm);
`else
    chk("perf_branches", perf_branches_o, 32'd0);
    chk("perf_mispredicts", perf_mispredicts_o, 32'd0);
`endif
  endfunction

  // Applies the rules at a rising edge using the inputs present before it.
  function automatic void model_upd();
    logic        acc, mis, br, stall;
    logic [31:0] nxt;
    ent_t        e;
    acc   = ex_valid_i && ex_is_branch_i && (flush_left == 0);
    nxt   = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    mis   = acc && (ex_pred_pc_i != nxt);
    br    = (mq.size() > 0) && !upd_hold_i;
    stall = (mq.size() == DEPTH) && !br;
    if (br) mq.delete(0);
    if (acc && !stall) begin
      e.pc  = ex_pc_i;
      e.tgt = ex_target_i;
      e.tk  = ex_taken_i;
      e.ghr = ex_ghr_i;
      mq.push_back(e);
    end
    if (acc && (m_pb != 32'hFFFF_FFFF)) m_pb = m_pb + 32'd1;
    if (mis && (m_pm != 32'hFFFF_FFFF)) m_pm = m_pm + 32'd1;
    m_rv = mis;
    if (mis) begin
      m_rpc      = nxt;
      flush_left = FC;
    end else if (flush_left > 0) begin
      flush_left--;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic b, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk, input logic [31:0] pred,
                       input logic [3:0] ghr, input logic hold);
    ex_valid_i      = v;
    ex_is_branch_i  = b;
    ex_pc_i         = pc;
    ex_target_i     = tgt;
    ex_taken_i      = tk;
    ex_pred_pc_i    = pred;
    ex_pred_valid_i = (pred != pc + 32'd4);
    ex_ghr_i        = ghr;
    upd_hold_i      = hold;
    #1;
  endtask

  task automatic idle(input logic hold);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 4'd0, hold);
  endtask

  task automatic tick(input bit use_model);
    @(negedge clk_i);
    if (use_model) model_cmp();
    @(posedge clk_i);
    model_upd();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
    chk({tag, "_rv"}, {31'd0, redirect_valid_o}, 32'd0);
    chk({tag, "_rpc"}, redirect_pc_o, 32'd0);
    chk({tag, "_stall"}, {31'd0, ex_stall_o}, 32'd0);
    chk({tag, "_br"}, {31'd0, branch_resolved_o}, 32'd0);
    chk({tag, "_pc"}, resolved_pc_o, 32'd0);
    chk({tag, "_alu"}, alu_out_o, 32'd0);
    chk({tag, "_tk"}, {31'd0, branch_taken_o}, 32'd0);
    chk({tag, "_ghr"}, {28'd0, ghr_history_o}, 32'd0);
    chk({tag, "_pb"}, perf_branches_o, 32'd0);
    chk({tag, "_pm"}, perf_mispredicts_o, 32'd0);
  endtask

  // Asserted between edges so the asynchronous clear is observed at once.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v, b;
    logic [31:0] pc, tgt;
    logic        tk;
    logic [31:0] pred;
    logic [3:0]  ghr;
    logic        hold;
    logic        e_fl, e_rv;
    logic [31:0] e_rpc;
    logic        e_st, e_br;
    logic [31:0] e_pc, e_alu;
    logic        e_tk;
    logic [3:0]  e_ghr;
    logic [31:0] e_pb, e_pm;
  } vec_t;

  localparam int NVec = 10;
  vec_t tab[NVec];

  initial begin
    logic [31:0] exp_pb, exp_pm;
    logic [31:0] drain_pc[4];
    logic [31:0] pc, tgt, nxt, pred;
    logic        tk;

    rst_i = 1'b1;
    idle(1'b0);
    do_reset("rst0");

    //            v  b  pc            tgt      tk pred     ghr hold fl rv rpc    st br e_pc          e_alu    tk ghr pb pm
    tab[0] = '{1, 1, 32'h100,      32'h200, 1, 32'h200, 1, 0,   0, 0, 32'h0,  0, 0, 32'h0,        32'h0,   0, 0, 0, 0};
    tab[1] = '{1, 1, 32'h204,      32'h300, 0, 32'h208, 2, 0,   0, 0, 32'h0,  0, 1, 32'h100,      32'h200, 1, 1, 1, 0};
    tab[2] = '{0, 0, 32'h0,        32'h0,   0, 32'h0,   0, 0,   0, 0, 32'h0,  0, 1, 32'h204,      32'h300, 0, 2, 2, 0};
    tab[3] = '{1, 1, 32'h40,       32'h80,  1, 32'h44,  3, 0,   0, 0, 32'h0,  0, 0, 32'h0,        32'h0,   0, 0, 2, 0};
    tab[4] = '{1, 1, 32'h500,      32'h600, 1, 32'h504, 6, 0,   1, 1, 32'h80, 0, 1, 32'h40,       32'h80,  1, 3, 3, 1};
    tab[5] = '{1, 1, 32'h500,      32'h600, 1, 32'h504, 6, 0,   1, 0, 32'h80, 0, 0, 32'h0,        32'h0,   0, 0, 3, 1};
    tab[6] = '{0, 0, 32'h0,        32'h0,   0, 32'h0,   0, 0,   0, 0, 32'h80, 0, 0, 32'h0,        32'h0,   0, 0, 3, 1};
    tab[7] = '{1, 1, 32'hFFFFFFFC, 32'h10,  0, 32'h0,   5, 0,   0, 0, 32'h80, 0, 0, 32'h0,        32'h0,   0, 0, 3, 1};
    tab[8] = '{0, 0, 32'h0,        32'h0,   0, 32'h0,   0, 0,   0, 0, 32'h80, 0, 1, 32'hFFFFFFFC, 32'h10,  0, 5, 4, 1};
    tab[9] = '{0, 0, 32'h0,        32'h0,   0, 32'h0,   0, 0,   0, 0, 32'h80, 0, 0, 32'h0,        32'h0,   0, 0, 4, 1};

    for (int i = 0; i < NVec; i++) begin
      drive(tab[i].v, tab[i].b, tab[i].pc, tab[i].tgt, tab[i].tk, tab[i].pred, tab[i].ghr,
            tab[i].hold);
      @(negedge clk_i);
`ifdef BRC_PERF_CNT_EN
      exp_pb = tab[i].e_pb;
      exp_pm = tab[i].e_pm;
`else
      exp_pb = 32'd0;
      exp_pm = 32'd0;
`endif
      chk($sformatf("vec%0d_flush", i), {31'd0, flush_o}, {31'd0, tab[i].e_fl});
      chk($sformatf("vec%0d_rv", i), {31'd0, redirect_valid_o}, {31'd0, tab[i].e_rv});
      chk($sformatf("vec%0d_rpc", i), redirect_pc_o, tab[i].e_rpc);
      chk($sformatf("vec%0d_stall", i), {31'd0, ex_stall_o}, {31'd0, tab[i].e_st});
      chk($sformatf("vec%0d_br", i), {31'd0, branch_resolved_o}, {31'd0, tab[i].e_br});
      chk($sformatf("vec%0d_pc", i), resolved_pc_o, tab[i].e_pc);
      chk($sformatf("vec%0d_alu", i), alu_out_o, tab[i].e_alu);
      chk($sformatf("vec%0d_tk", i), {31'd0, branch_taken_o}, {31'd0, tab[i].e_tk});
      chk($sformatf("vec%0d_ghr", i), {28'd0, ghr_history_o}, {28'd0, tab[i].e_ghr});
      chk($sformatf("vec%0d_pb", i), perf_branches_o, exp_pb);
      chk($sformatf("vec%0d_pm", i), perf_mispredicts_o, exp_pm);
      @(posedge clk_i);
      model_upd();
      #1;
    end

    // ---------------- fill with hold, then drain across the wrap ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h1000 + 32'(16 * i), 32'h0, 1'b0, 32'h1004 + 32'(16 * i),
            4'(i), 1'b1);
      chk($sformatf("fill%0d_stall", i), {31'd0, ex_stall_o}, 32'd0);
      tick(1'b1);
    end
    drive(1'b1, 1'b1, 32'h2000, 32'h2400, 1'b1, 32'h2400, 4'd9, 1'b1);
    chk("full_stall", {31'd0, ex_stall_o}, 32'd1);
    tick(1'b1);
    tick(1'b1);
    // Full while draining: the 5th branch goes in, occupancy stays at DEPTH.
    drive(1'b1, 1'b1, 32'h2000, 32'h2400, 1'b1, 32'h2400, 4'd9, 1'b0);
    chk("full_drain_stall", {31'd0, ex_stall_o}, 32'd0);
    chk("full_drain_head", resolved_pc_o, 32'h1000);
    tick(1'b1);
    idle(1'b1);
    chk("still_full", {31'd0, ex_stall_o}, 32'd1);
    tick(1'b1);
    drain_pc[0] = 32'h1010;
    drain_pc[1] = 32'h1020;
    drain_pc[2] = 32'h1030;
    drain_pc[3] = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk($sformatf("drain%0d_br", i), {31'd0, branch_resolved_o}, 32'd1);
      chk($sformatf("drain%0d_pc", i), resolved_pc_o, drain_pc[i]);
      tick(1'b1);
    end
    idle(1'b0);
    chk("drained_empty", {31'd0, branch_resolved_o}, 32'd0);
    tick(1'b1);

    // ---------------- reset mid-flush with a non-empty queue ----------------
    drive(1'b1, 1'b1, 32'h3000, 32'h4000, 1'b1, 32'h3004, 4'd7, 1'b1);
    tick(1'b1);
    idle(1'b1);
    chk("pre_rst_flush", {31'd0, flush_o}, 32'd1);
    chk("pre_rst_rpc", redirect_pc_o, 32'h4000);
    do_reset("midflush");
    idle(1'b0);
    chk("post_rst_br", {31'd0, branch_resolved_o}, 32'd0);
    chk("post_rst_stall", {31'd0, ex_stall_o}, 32'd0);
    tick(1'b1);

    // ---------------- randomized phase ----------------
    for (int n = 0; n < 1500; n++) begin
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      tgt = $urandom() & 32'hFFFF_FFFC;
      tk  = 1'($urandom_range(0, 1));
      nxt = tk ? tgt : pc + 32'd4;
      pred = ($urandom_range(0, 4) == 0) ? nxt + 32'd8 : nxt;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), pc, tgt, tk, pred,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
      tick(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
